// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcode classes, datapath control constants.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_ERROR
   } state_e;

   localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
   localparam logic [4:0] OPCODE_FENCE  = 5'b00011;
   localparam logic [4:0] OPCODE_OPIMM  = 5'b00100;
   localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
   localparam logic [4:0] OPCODE_STORE  = 5'b01000;
   localparam logic [4:0] OPCODE_OP     = 5'b01100;
   localparam logic [4:0] OPCODE_LUI    = 5'b01101;
   localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
   localparam logic [4:0] OPCODE_JALR   = 5'b11001;
   localparam logic [4:0] OPCODE_JAL    = 5'b11011;
   localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

   localparam logic [2:0] ALUOp_Add   = 3'd0;
   localparam logic [2:0] ALUOp_Btype = 3'd1;
   localparam logic [2:0] ALUOp_Rtype = 3'd2;
   localparam logic [2:0] ALUOp_Itype = 3'd3;
   localparam logic [2:0] ALUOp_Lui   = 3'd4;
   localparam logic [2:0] ALUOp_Auipc = 3'd5;
   localparam logic [2:0] ALUOp_Jump  = 3'd6;

   localparam logic [1:0] MemToRegAlu   = 2'd0;
   localparam logic [1:0] MemToRegMem   = 2'd1;
   localparam logic [1:0] MemToRegPc4   = 2'd2;
   localparam logic [1:0] MemToRegAuipc = 2'd3;

   localparam logic [1:0] BranchNormal = 2'd0;
   localparam logic [1:0] BranchCond   = 2'd1;
   localparam logic [1:0] BranchJal    = 2'd2;
   localparam logic [1:0] BranchJalr   = 2'd3;

   typedef struct packed {
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
      logic       is_system;
      logic       is_fence;
      logic       illegal;
      logic       alu_src;
      logic [2:0] alu_op;
      logic [1:0] mem_to_reg;
      logic [1:0] branch_signal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_control_decode.sv
// Combinational opcode decode into the raw, state-independent
// control class; the FSM qualifies these by state.
module control_decode
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output ctrl_t               ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (opcode_i)
         OPCODE_W'(OPCODE_LOAD): begin
            ctrl_o.is_load    = 1'b1;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.alu_op     = ALUOp_Add;
            ctrl_o.mem_to_reg = MemToRegMem;
         end
         OPCODE_W'(OPCODE_STORE): begin
            ctrl_o.is_store = 1'b1;
            ctrl_o.alu_src  = 1'b1;
            ctrl_o.alu_op   = ALUOp_Add;
         end
         OPCODE_W'(OPCODE_OP): begin
            ctrl_o.alu_op = ALUOp_Rtype;
         end
         OPCODE_W'(OPCODE_OPIMM): begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALUOp_Itype;
         end
         OPCODE_W'(OPCODE_LUI): begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALUOp_Lui;
         end
         OPCODE_W'(OPCODE_AUIPC): begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.alu_op     = ALUOp_Auipc;
            ctrl_o.mem_to_reg = MemToRegAuipc;
         end
         OPCODE_W'(OPCODE_BRANCH): begin
            ctrl_o.is_branch     = 1'b1;
            ctrl_o.alu_op        = ALUOp_Btype;
            ctrl_o.branch_signal = BranchCond;
         end
         OPCODE_W'(OPCODE_JAL): begin
            ctrl_o.is_jump       = 1'b1;
            ctrl_o.alu_op        = ALUOp_Jump;
            ctrl_o.mem_to_reg    = MemToRegPc4;
            ctrl_o.branch_signal = BranchJal;
         end
         OPCODE_W'(OPCODE_JALR): begin
            ctrl_o.is_jump       = 1'b1;
            ctrl_o.alu_src       = 1'b1;
            ctrl_o.alu_op        = ALUOp_Jump;
            ctrl_o.mem_to_reg    = MemToRegPc4;
            ctrl_o.branch_signal = BranchJalr;
         end
         OPCODE_W'(OPCODE_SYSTEM): ctrl_o.is_system = 1'b1;
         OPCODE_W'(OPCODE_FENCE):  ctrl_o.is_fence  = 1'b1;
         default:                  ctrl_o.illegal   = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over one shared
// memory port; owns PC update timing and IR latching.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int unsigned OPCODE_W       = 5,
   parameter int unsigned MEM_TIMEOUT    = 255,
   parameter bit          HALT_ON_SYSTEM = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_is_instr,
   output logic                ir_write,
   output logic                pc_write,
   output logic                Branch,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                ALUSrc,
   output logic                RegWrite,
   output logic [1:0]          MemtoReg,
   output logic [2:0]          ALUOp,
   output logic [1:0]          branch_signal,
   output logic                instr_retired,
   output logic                illegal_instr,
   output logic                halted,
   output logic                mem_err
);

   localparam int unsigned CNT_W =
      (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            dec;

   logic       mem_req_q, mem_is_instr_q, mem_read_q, mem_write_q;
   logic       branch_q, alu_src_q, reg_write_q, halted_q, mem_err_q;
   logic [1:0] mem_to_reg_q, branch_signal_q;
   logic [2:0] alu_op_q;

   logic waiting, handshake, timeout, hold_d;

   control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode_i (opcode),
      .ctrl_o   (dec)
   );

   // Handshake pulses follow mem_ready in the same cycle so the IR
   // and PC latch while the memory data is still valid.
   always_comb begin
      waiting       = mem_req_q && !mem_ready;
      handshake     = mem_req_q && mem_ready;
      timeout       = TIMEOUT_EN && waiting && (cnt_q == CNT_LAST);
      cnt_d         = waiting ? cnt_q + CNT_W'(1) : '0;
      state_d       = state_q;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      instr_retired = 1'b0;
      illegal_instr = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (timeout) begin
               state_d = S_ERROR;
            end else if (handshake) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            illegal_instr = dec.illegal;
            if (dec.is_system && HALT_ON_SYSTEM) begin
               state_d = S_HALT;
            end else if (dec.illegal || dec.is_fence || dec.is_system) begin
               pc_write      = 1'b1;
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            unique case (1'b1)
               dec.is_branch: begin
                  pc_write      = 1'b1;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end
               dec.is_load, dec.is_store: state_d = S_MEM;
               dec.is_jump:               state_d = S_WB;
               default:                   state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (timeout) begin
               state_d = S_ERROR;
            end else if (handshake) begin
               if (dec.is_store) begin
                  pc_write      = 1'b1;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            pc_write      = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_HALT, S_ERROR: state_d = state_q;
         default:         state_d = S_FETCH;
      endcase
      if (rst) begin
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         instr_retired = 1'b0;
         illegal_instr = 1'b0;
      end
      hold_d = (state_d == S_EXEC) || (state_d == S_MEM) ||
               (state_d == S_WB);
   end

   // Level controls are registered from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_FETCH;
         cnt_q           <= '0;
         mem_req_q       <= 1'b0;
         mem_is_instr_q  <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         branch_q        <= 1'b0;
         alu_src_q       <= 1'b0;
         reg_write_q     <= 1'b0;
         mem_to_reg_q    <= '0;
         alu_op_q        <= '0;
         branch_signal_q <= '0;
         halted_q        <= 1'b0;
         mem_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         mem_req_q       <= (state_d == S_FETCH) || (state_d == S_MEM);
         mem_is_instr_q  <= (state_d == S_FETCH);
         mem_read_q      <= (state_d == S_FETCH) ||
                            ((state_d == S_MEM) && dec.is_load);
         mem_write_q     <= (state_d == S_MEM) && dec.is_store;
         branch_q        <= (state_d == S_EXEC) && dec.is_branch;
         reg_write_q     <= (state_d == S_WB);
         alu_src_q       <= hold_d && dec.alu_src;
         mem_to_reg_q    <= hold_d ? dec.mem_to_reg : MemToRegAlu;
         alu_op_q        <= hold_d ? dec.alu_op : ALUOp_Add;
         branch_signal_q <= hold_d ? dec.branch_signal : BranchNormal;
         halted_q        <= (state_d == S_HALT);
         mem_err_q       <= (state_d == S_ERROR);
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = mem_write_q;
   assign mem_is_instr  = mem_is_instr_q;
   assign Branch        = branch_q;
   assign MemRead       = mem_read_q;
   assign MemWrite      = mem_write_q;
   assign ALUSrc        = alu_src_q;
   assign RegWrite      = reg_write_q;
   assign MemtoReg      = mem_to_reg_q;
   assign ALUOp         = alu_op_q;
   assign branch_signal = branch_signal_q;
   assign halted        = halted_q;
   assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle vector table plus hand sequences for
// HALT, timeout and reset corner cases.
module tb_multicycle_control_unit;

   localparam logic [4:0] LD = 5'b00000, FN = 5'b00011, AU = 5'b00101;
   localparam logic [4:0] ST = 5'b01000, RT = 5'b01100, LU = 5'b01101;
   localparam logic [4:0] BR = 5'b11000, JR = 5'b11001, JL = 5'b11011;
   localparam logic [4:0] SY = 5'b11100, IL = 5'b11111;

   // {req,we,is_instr,ir_write,pc_write,Branch,MemRead,MemWrite,ALUSrc,RegWrite}
   localparam logic [9:0] C0   = 10'b0000000000;
   localparam logic [9:0] CF   = 10'b1011001000;
   localparam logic [9:0] CFW  = 10'b1010001000;
   localparam logic [9:0] CI   = 10'b0000000010;
   localparam logic [9:0] CWB  = 10'b0000100001;
   localparam logic [9:0] CWBI = 10'b0000100011;
   localparam logic [9:0] CNOP = 10'b0000100000;
   localparam logic [9:0] CLDM = 10'b1000001010;
   localparam logic [9:0] CSTM = 10'b1100100110;
   localparam logic [9:0] CBRE = 10'b0000110000;
   // {MemtoReg,ALUOp,branch_signal}
   localparam logic [6:0] K0   = 7'b00_000_00;
   localparam logic [6:0] KR   = 7'b00_010_00;
   localparam logic [6:0] KLD  = 7'b01_000_00;
   localparam logic [6:0] KBR  = 7'b00_001_01;
   localparam logic [6:0] KJL  = 7'b10_110_10;
   localparam logic [6:0] KJR  = 7'b10_110_11;
   localparam logic [6:0] KAU  = 7'b11_101_00;
   localparam logic [6:0] KLU  = 7'b00_100_00;
   // {instr_retired,illegal_instr,halted,mem_err}
   localparam logic [3:0] S0 = 4'b0000, SR = 4'b1000, SI = 4'b1100;

   typedef struct {
      logic       rst;
      logic [4:0] opc;
      logic       rdy;
      logic [9:0] ctl;
      logic [6:0] cls;
      logic [3:0] st;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] opcode = '0;
   logic       mem_ready = 1'b0;

   logic a_req, a_we, a_ins, a_irw, a_pcw, a_br, a_mrd, a_mwr, a_src, a_rgw;
   logic a_ret, a_ill, a_hlt, a_err;
   logic [1:0] a_m2r, a_bs;
   logic [2:0] a_alu;
   logic b_req, b_we, b_ins, b_irw, b_pcw, b_br, b_mrd, b_mwr, b_src, b_rgw;
   logic b_ret, b_ill, b_hlt, b_err;
   logic [1:0] b_m2r, b_bs;
   logic [2:0] b_alu;
   logic [20:0] av, bv;

   always #5 clk = ~clk;

   multicycle_control_unit #(
      .OPCODE_W(5), .MEM_TIMEOUT(4), .HALT_ON_SYSTEM(1'b1)
   ) u_a (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(a_req), .mem_we(a_we), .mem_is_instr(a_ins),
      .ir_write(a_irw), .pc_write(a_pcw), .Branch(a_br),
      .MemRead(a_mrd), .MemWrite(a_mwr), .ALUSrc(a_src),
      .RegWrite(a_rgw), .MemtoReg(a_m2r), .ALUOp(a_alu),
      .branch_signal(a_bs), .instr_retired(a_ret),
      .illegal_instr(a_ill), .halted(a_hlt), .mem_err(a_err)
   );

   multicycle_control_unit #(
      .OPCODE_W(5), .MEM_TIMEOUT(0), .HALT_ON_SYSTEM(1'b0)
   ) u_b (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(b_req), .mem_we(b_we), .mem_is_instr(b_ins),
      .ir_write(b_irw), .pc_write(b_pcw), .Branch(b_br),
      .MemRead(b_mrd), .MemWrite(b_mwr), .ALUSrc(b_src),
      .RegWrite(b_rgw), .MemtoReg(b_m2r), .ALUOp(b_alu),
      .branch_signal(b_bs), .instr_retired(b_ret),
      .illegal_instr(b_ill), .halted(b_hlt), .mem_err(b_err)
   );

   assign av = {a_req, a_we, a_ins, a_irw, a_pcw, a_br, a_mrd, a_mwr,
                a_src, a_rgw, a_m2r, a_alu, a_bs, a_ret, a_ill, a_hlt, a_err};
   assign bv = {b_req, b_we, b_ins, b_irw, b_pcw, b_br, b_mrd, b_mwr,
                b_src, b_rgw, b_m2r, b_alu, b_bs, b_ret, b_ill, b_hlt, b_err};

   function automatic void add(input logic r, input logic [4:0] o,
                               input logic m, input logic [9:0] c,
                               input logic [6:0] k, input logic [3:0] s);
      vec_t v;
      v.rst = r; v.opc = o; v.rdy = m;
      v.ctl = c; v.cls = k; v.st = s;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [20:0] got,
                      input logic [20:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", nm, got, want);
      end
   endtask

   task automatic step(input logic r, input logic [4:0] o, input logic m);
      @(negedge clk);
      rst = r; opcode = o; mem_ready = m;
      #2;
   endtask

   initial begin
      add(1, RT, 0, C0, K0, S0);
      add(0, RT, 1, C0, K0, S0);
      add(0, RT, 1, CF, K0, S0);   add(0, RT, 1, C0, K0, S0);
      add(0, RT, 1, C0, KR, S0);   add(0, RT, 1, CWB, KR, SR);
      add(0, LD, 1, CF, K0, S0);   add(0, LD, 1, C0, K0, S0);
      add(0, LD, 1, CI, KLD, S0);  add(0, LD, 0, CLDM, KLD, S0);
      add(0, LD, 0, CLDM, KLD, S0); add(0, LD, 0, CLDM, KLD, S0);
      add(0, LD, 1, CLDM, KLD, S0); add(0, LD, 1, CWBI, KLD, SR);
      add(0, ST, 1, CF, K0, S0);   add(0, ST, 1, C0, K0, S0);
      add(0, ST, 1, CI, K0, S0);   add(0, ST, 1, CSTM, K0, SR);
      add(0, BR, 1, CF, K0, S0);   add(0, BR, 1, C0, K0, S0);
      add(0, BR, 1, CBRE, KBR, SR);
      add(0, JL, 1, CF, K0, S0);   add(0, JL, 1, C0, K0, S0);
      add(0, JL, 1, C0, KJL, S0);  add(0, JL, 1, CWB, KJL, SR);
      add(0, FN, 1, CF, K0, S0);   add(0, FN, 1, CNOP, K0, SR);
      add(0, IL, 1, CF, K0, S0);   add(0, IL, 1, CNOP, K0, SI);
      add(0, JR, 0, CFW, K0, S0);  add(0, JR, 0, CFW, K0, S0);
      add(0, JR, 1, CF, K0, S0);   add(0, JR, 1, C0, K0, S0);
      add(0, JR, 1, CI, KJR, S0);  add(0, JR, 1, CWBI, KJR, SR);
      add(0, AU, 1, CF, K0, S0);   add(0, AU, 1, C0, K0, S0);
      add(0, AU, 1, CI, KAU, S0);  add(0, AU, 1, CWBI, KAU, SR);
      add(0, LU, 1, CF, K0, S0);   add(0, LU, 1, C0, K0, S0);
      add(0, LU, 1, CI, KLU, S0);  add(0, LU, 1, CWBI, KLU, SR);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].opc, tbl[i].rdy);
         chk($sformatf("vec%0d.a", i), av, {tbl[i].ctl, tbl[i].cls, tbl[i].st});
         chk($sformatf("vec%0d.b", i), bv, {tbl[i].ctl, tbl[i].cls, tbl[i].st});
      end

      // SYSTEM: a halts, b retires it as a NOP
      step(1, SY, 0);
      step(0, SY, 1);
      chk("sys.req_after_rst", a_req, 1'b0);
      step(0, SY, 1);
      chk("sys.fetch_irw", {a_irw, a_req}, 2'b11);
      step(0, SY, 1);
      chk("sys.dec.a", {a_pcw, a_ret, a_hlt}, 3'b000);
      chk("sys.dec.b", {b_pcw, b_ret, b_hlt}, 3'b110);
      step(0, SY, 1);
      chk("sys.c3.a", {a_hlt, a_req}, 2'b10);
      chk("sys.c3.b", {b_req, b_ins, b_hlt}, 3'b110);
      for (int i = 0; i < 20; i++) begin
         step(0, SY, 1);
         chk($sformatf("halt%0d", i),
             {a_hlt, a_req, a_pcw, a_irw, a_err, a_rgw}, 6'b100000);
      end
      step(1, SY, 0);
      step(0, RT, 0);
      chk("halt.rst", {a_hlt, a_req}, 2'b00);
      step(0, RT, 0);
      chk("halt.refetch", {a_hlt, a_req, a_ins}, 3'b011);

      // timeout: a errors after 4 wait cycles, b never times out
      step(1, RT, 0);
      step(0, RT, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, RT, 0);
         chk($sformatf("tmo%0d.a", i), {a_req, a_err, a_pcw},
             (i < 4) ? 3'b100 : 3'b010);
         chk($sformatf("tmo%0d.b", i), {b_req, b_err}, 2'b10);
      end
      step(1, RT, 0);
      step(0, RT, 0);
      chk("rst.err.a", {a_err, a_req}, 2'b00);
      chk("rst.wait.b", b_req, 1'b0);
      step(0, RT, 1);
      chk("rst.fetch.a", {a_req, a_irw, a_err}, 3'b110);
      chk("rst.fetch.b", {b_req, b_irw}, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
